// File: rtl/mux_display_n.sv
// Multiplexed N-digit 7-segment driver with double-buffered updates, per-digit
// blank/blink masks, a blinkable colon and leading-zero suppression.
module mux_display_n #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DWELL      = 1,
  parameter int unsigned BLINK_HALF = 125
) (
  input  logic                    clk_500Hz,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic                    update,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lz_en,
  input  logic                    colon_en,
  input  logic                    colon_blink,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    colon,
  output logic                    frame_done
);

  localparam int unsigned SW = $clog2(NUM_DIGITS);
  localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  typedef logic [NUM_DIGITS-1:0][3:0] dig_t;

  dig_t                  stg_dig_q, stg_dig_d, shd_dig_q, shd_dig_d;
  logic [NUM_DIGITS-1:0] stg_blank_q, stg_blank_d, stg_blink_q, stg_blink_d;
  logic [NUM_DIGITS-1:0] shd_blank_q, shd_blank_d, shd_blink_q, shd_blink_d;
  logic                  pending_q, pending_d;
  logic [SW-1:0]         sel_q, sel_d;
  logic [DW-1:0]         dwell_q, dwell_d;
  logic [BW-1:0]         blink_q, blink_d;
  logic                  phase_q, phase_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic                  colon_q, colon_d;
  logic                  frame_done_q, frame_done_d;

  logic                  dwell_wrap, sel_last, boundary, blink_wrap, hide, run;
  logic [NUM_DIGITS-1:0] lz_vec;
  logic [3:0]            cur;

  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    case (code)
      4'd0:    seg_decode = 7'b0000001;
      4'd1:    seg_decode = 7'b1001111;
      4'd2:    seg_decode = 7'b0010010;
      4'd3:    seg_decode = 7'b0000110;
      4'd4:    seg_decode = 7'b1001100;
      4'd5:    seg_decode = 7'b0100100;
      4'd6:    seg_decode = 7'b0100000;
      4'd7:    seg_decode = 7'b0001111;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0000100;
      4'd10:   seg_decode = 7'b1111110;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    dwell_wrap = (dwell_q == DW'(DWELL - 1));
    dwell_d    = dwell_wrap ? '0 : dwell_q + 1'b1;
    sel_last   = (sel_q == SW'(NUM_DIGITS - 1));
    sel_d      = sel_q;
    if (dwell_wrap) sel_d = sel_last ? '0 : sel_q + 1'b1;
    boundary   = dwell_wrap & sel_last;

    blink_wrap = (blink_q == BW'(BLINK_HALF - 1));
    blink_d    = blink_wrap ? '0 : blink_q + 1'b1;
    phase_d    = blink_wrap ? ~phase_q : phase_q;

    stg_dig_d   = stg_dig_q;
    stg_blank_d = stg_blank_q;
    stg_blink_d = stg_blink_q;
    pending_d   = pending_q;
    if (update) begin
      stg_dig_d   = digits;
      stg_blank_d = blank_mask;
      stg_blink_d = blink_mask;
      pending_d   = 1'b1;
    end

    // A strobe landing on the boundary bypasses staging so it is not a frame late.
    shd_dig_d   = shd_dig_q;
    shd_blank_d = shd_blank_q;
    shd_blink_d = shd_blink_q;
    if (boundary) begin
      if (update) begin
        shd_dig_d   = digits;
        shd_blank_d = blank_mask;
        shd_blink_d = blink_mask;
      end else if (pending_q) begin
        shd_dig_d   = stg_dig_q;
        shd_blank_d = stg_blank_q;
        shd_blink_d = stg_blink_q;
      end
      pending_d = 1'b0;
    end

    // lz_vec[i] is set when nibbles i..top are all zero.
    run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run       = run & (shd_dig_q[i] == 4'd0);
      lz_vec[i] = run;
    end

    cur  = shd_dig_q[sel_q];
    hide = shd_blank_q[sel_q] | (shd_blink_q[sel_q] & phase_q) |
           (lz_en & (sel_q != '0) & lz_vec[sel_q]);
    seg_d        = hide ? 7'b1111111 : seg_decode(cur);
    anode_d      = ~({{(NUM_DIGITS - 1){1'b0}}, 1'b1} << sel_q);
    colon_d      = colon_en & ~(colon_blink & phase_q);
    frame_done_d = boundary;
  end

  always_ff @(posedge clk_500Hz) begin
    if (!reset) begin
      stg_dig_q    <= '1;
      shd_dig_q    <= '1;
      stg_blank_q  <= '0;
      stg_blink_q  <= '0;
      shd_blank_q  <= '0;
      shd_blink_q  <= '0;
      pending_q    <= 1'b0;
      sel_q        <= '0;
      dwell_q      <= '0;
      blink_q      <= '0;
      phase_q      <= 1'b0;
      seg_q        <= 7'b1111111;
      anode_q      <= '1;
      colon_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      stg_dig_q    <= stg_dig_d;
      shd_dig_q    <= shd_dig_d;
      stg_blank_q  <= stg_blank_d;
      stg_blink_q  <= stg_blink_d;
      shd_blank_q  <= shd_blank_d;
      shd_blink_q  <= shd_blink_d;
      pending_q    <= pending_d;
      sel_q        <= sel_d;
      dwell_q      <= dwell_d;
      blink_q      <= blink_d;
      phase_q      <= phase_d;
      seg_q        <= seg_d;
      anode_q      <= anode_d;
      colon_q      <= colon_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign anode      = anode_q;
  assign colon      = colon_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_mux_display_n.sv
// Bench for mux_display_n: an edge-count based reference model for a 4-digit
// instance plus directed literal checks, and a 6-digit/3-dwell scan instance.
module tb_mux_display_n;

  localparam int ND4 = 4;
  localparam int DW4 = 1;
  localparam int BH4 = 4;
  localparam int FR4 = ND4 * DW4;

  logic        clk;
  logic        reset, update, lz_en, colon_en, colon_blink;
  logic [15:0] digits;
  logic [3:0]  blank_mask, blink_mask;
  logic [6:0]  seg;
  logic [3:0]  anode;
  logic        colon, frame_done;

  logic        reset6;
  logic [23:0] digits6;
  logic [6:0]  seg6;
  logic [5:0]  anode6;
  logic        colon6, frame_done6;

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tab [0:15] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100, 7'b1111110, 7'b1111111,
                                 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};

  mux_display_n #(.NUM_DIGITS(4), .DWELL(1), .BLINK_HALF(4)) u_dut (
    .clk_500Hz   (clk),
    .reset       (reset),
    .digits      (digits),
    .update      (update),
    .blank_mask  (blank_mask),
    .blink_mask  (blink_mask),
    .lz_en       (lz_en),
    .colon_en    (colon_en),
    .colon_blink (colon_blink),
    .seg         (seg),
    .anode       (anode),
    .colon       (colon),
    .frame_done  (frame_done)
  );

  mux_display_n #(.NUM_DIGITS(6), .DWELL(3), .BLINK_HALF(4)) u_dut6 (
    .clk_500Hz   (clk),
    .reset       (reset6),
    .digits      (digits6),
    .update      (1'b0),
    .blank_mask  (6'b0),
    .blink_mask  (6'b0),
    .lz_en       (1'b0),
    .colon_en    (1'b0),
    .colon_blink (1'b0),
    .seg         (seg6),
    .anode       (anode6),
    .colon       (colon6),
    .frame_done  (frame_done6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference model: expected outputs derive from the edge count since reset release.
  initial begin : model
    int          k, d, ph;
    logic        r_s, u_s, lz_s, ce_s, cb_s, m_hide;
    logic [15:0] d_s, m_disp, m_stg;
    logic [3:0]  bm_s, km_s, m_dbm, m_dkm, m_sbm, m_skm, m_nib;
    logic        m_pend;
    logic [6:0]  e_seg;
    logic [3:0]  e_an;
    logic        e_col, e_fd;
    k = 0; m_disp = 16'hFFFF; m_stg = 16'hFFFF; m_pend = 1'b0;
    m_dbm = '0; m_dkm = '0; m_sbm = '0; m_skm = '0;
    forever begin
      @(posedge clk);
      r_s = reset; u_s = update; d_s = digits; bm_s = blank_mask; km_s = blink_mask;
      lz_s = lz_en; ce_s = colon_en; cb_s = colon_blink;
      if (!r_s) begin
        k = 0; e_seg = 7'h7F; e_an = 4'hF; e_col = 1'b0; e_fd = 1'b0;
      end else begin
        k++;
        d      = ((k - 1) / DW4) % ND4;
        ph     = ((k - 1) / BH4) % 2;
        m_nib  = m_disp[4*d +: 4];
        m_hide = m_dbm[d] || (m_dkm[d] && ph == 1) ||
                 (lz_s && d != 0 && (m_disp >> (4 * d)) == 16'h0);
        e_seg  = m_hide ? 7'h7F : seg_tab[m_nib];
        e_an   = ~(4'b0001 << d);
        e_col  = ce_s && !(cb_s && ph == 1);
        e_fd   = (k % FR4) == 0;
      end
      #1;
      chk($sformatf("model_seg k%0d", k), 32'(seg), 32'(e_seg));
      chk($sformatf("model_anode k%0d", k), 32'(anode), 32'(e_an));
      chk($sformatf("model_colon k%0d", k), 32'(colon), 32'(e_col));
      chk($sformatf("model_frame_done k%0d", k), 32'(frame_done), 32'(e_fd));
      if (!r_s) begin
        m_disp = 16'hFFFF; m_stg = 16'hFFFF; m_pend = 1'b0;
        m_dbm = '0; m_dkm = '0; m_sbm = '0; m_skm = '0;
      end else if (k % FR4 == 0) begin
        if (u_s) begin
          m_disp = d_s; m_dbm = bm_s; m_dkm = km_s;
          m_stg = d_s; m_sbm = bm_s; m_skm = km_s;
        end else if (m_pend) begin
          m_disp = m_stg; m_dbm = m_sbm; m_dkm = m_skm;
        end
        m_pend = 1'b0;
      end else if (u_s) begin
        m_stg = d_s; m_sbm = bm_s; m_skm = km_s; m_pend = 1'b1;
      end
    end
  end

  initial begin : stim
    logic [5:0] e_an6;
    int         last_fd;
    reset = 1'b0; update = 1'b0; digits = 16'h0; blank_mask = '0; blink_mask = '0;
    lz_en = 1'b0; colon_en = 1'b1; colon_blink = 1'b0;
    reset6 = 1'b0; digits6 = 24'h0;

    repeat (3) tick();
    chk("reset_anode", 32'(anode), 32'hF);
    chk("reset_seg", 32'(seg), 32'h7F);
    chk("reset_colon", 32'(colon), 32'h0);
    chk("reset_frame_done", 32'(frame_done), 32'h0);

    reset = 1'b1;
    tick(); chk("scan_e1", 32'(anode), 32'b1110);
    tick(); chk("scan_e2", 32'(anode), 32'b1101);
    tick(); chk("scan_e3", 32'(anode), 32'b1011);
    tick(); chk("scan_e4", 32'(anode), 32'b0111);
    tick(); chk("scan_e5", 32'(anode), 32'b1110);

    // Update sampled at edge 7 (sel=2); visible from edge 9.
    tick();
    digits = 16'h1234; update = 1'b1;
    tick(); update = 1'b0; digits = 16'h0;
    chk("midframe_still_blank", 32'(seg), 32'h7F);
    tick(); chk("midframe_fd", 32'(frame_done), 32'h1);
    tick(); chk("upd_d0_seg", 32'(seg), 32'b1001100);
    chk("upd_d0_anode", 32'(anode), 32'b1110);
    tick(); tick();
    tick(); chk("upd_d3_seg", 32'(seg), 32'b1001111);

    // Two updates in one frame: only the second survives.
    digits = 16'h1111; update = 1'b1;
    tick(); digits = 16'h2222;
    tick(); update = 1'b0; digits = 16'h0;
    tick(); tick();
    tick(); chk("latest_wins_d0", 32'(seg), 32'b0010010);

    // Update coincident with boundary at edge 20.
    tick(); tick();
    digits = 16'h5678; update = 1'b1;
    tick(); update = 1'b0; digits = 16'h0;
    tick(); chk("coincident_d0", 32'(seg), 32'b0000000);

    lz_en = 1'b1; digits = 16'h0050; update = 1'b1;
    tick(); update = 1'b0;
    repeat (3) tick();
    chk("lz_d0", 32'(seg), 32'b0000001);
    tick(); chk("lz_d1", 32'(seg), 32'b0100100);
    tick(); chk("lz_d2", 32'(seg), 32'h7F);
    tick(); chk("lz_d3", 32'(seg), 32'h7F);
    digits = 16'h0000; update = 1'b1;
    tick(); update = 1'b0;
    repeat (3) tick();
    tick(); chk("lz_zero_d0", 32'(seg), 32'b0000001);
    tick(); chk("lz_zero_d1", 32'(seg), 32'h7F);

    // Blink: loaded at edge 36; phase is 1 for edges 37..40, 0 for 41..44.
    lz_en = 1'b0; digits = 16'h1234; blink_mask = 4'b0001; blank_mask = 4'b1000;
    colon_blink = 1'b1; update = 1'b1;
    tick(); update = 1'b0;
    tick();
    tick(); chk("blink_off_d0", 32'(seg), 32'h7F);
    chk("blink_off_colon", 32'(colon), 32'h0);
    tick(); tick();
    tick(); chk("blank_d3_a", 32'(seg), 32'h7F);
    tick(); chk("blink_on_d0", 32'(seg), 32'b1001100);
    chk("blink_on_colon", 32'(colon), 32'h1);
    tick(); tick();
    tick(); chk("blank_d3_b", 32'(seg), 32'h7F);
    repeat (16) tick();

    // Reset mid-frame discards a pending update.
    digits = 16'h9999; update = 1'b1;
    tick(); update = 1'b0; reset = 1'b0;
    tick(); chk("midreset_anode", 32'(anode), 32'hF);
    chk("midreset_seg", 32'(seg), 32'h7F);
    reset = 1'b1;
    tick(); chk("post_reset_anode", 32'(anode), 32'b1110);
    chk("pending_discarded", 32'(seg), 32'h7F);
    repeat (8) tick();

    // Six digits, dwell 3.
    reset6 = 1'b1;
    last_fd = 0;
    for (int e = 1; e <= 48; e++) begin
      tick();
      e_an6 = ~(6'b000001 << (((e - 1) / 3) % 6));
      chk($sformatf("n6_anode e%0d", e), 32'(anode6), 32'(e_an6));
      chk($sformatf("n6_fd e%0d", e), 32'(frame_done6), 32'((e % 18) == 0));
      if (frame_done6) begin
        if (last_fd > 0) chk("n6_frame_period", 32'(e - last_fd), 32'd18);
        last_fd = e;
      end
    end
    reset6 = 1'b0;
    tick(); chk("n6_reset_at_sel4", 32'(anode6), 32'h3F);
    chk("n6_reset_fd", 32'(frame_done6), 32'h0);
    reset6 = 1'b1;
    tick(); chk("n6_restart", 32'(anode6), 32'b111110);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
